// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared defaults and types for the multiplier scheduler
package mult_sched_pkg;

  localparam int WIDTH_DEF  = 8;
  localparam int STAGES_DEF = 3;
  localparam int NREQ_DEF   = 4;

  localparam int ID_W   = $clog2(NREQ_DEF);
  localparam int INFL_W = $clog2(STAGES_DEF + 2);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mult_scheduler_rr_arbiter.sv
// rtl/mult_scheduler_rr_arbiter.sv - round-robin arbiter with one-hot grant
module rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic            update,
  output logic [NREQ-1:0] grant
);

  localparam int IDB = $clog2(NREQ);

  logic [IDB-1:0] ptr;
  logic [IDB-1:0] win;
  logic [IDB-1:0] idx;
  logic           found;

  // search from the slot after the last winner, wrapping; first active requester wins
  always_comb begin
    grant = '0;
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDB'((int'(ptr) + k) % NREQ);
      if (!found && en && req[idx]) begin
        grant[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
    end
  end

  // pointer remembers the last winner so requester 0 goes first out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= IDB'(NREQ - 1);
    end else if (update) begin
      ptr <= win;
    end
  end

endmodule

// File: rtl/mult_scheduler.sv
// rtl/mult_scheduler.sv - round-robin issue of operand pairs into a shared pipelined multiplier
module mult_scheduler
  import mult_sched_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int NREQ   = NREQ_DEF,
  localparam int IDB   = $clog2(NREQ),
  localparam int CNTB  = $clog2(STAGES + 2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_product,
  output logic                  rsp_valid,
  output logic [IDB-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic [CNTB-1:0]       inflight,
  output logic                  idle
);

  logic [NREQ-1:0]  grant;
  logic             accept;
  logic [IDB-1:0]   win_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  // tag stage 0 sits alongside the operand register; stage STAGES lines up with mul_product
  logic [STAGES:0]  tag_v;
  logic [IDB-1:0]   tag_id [0:STAGES];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .en     (en),
    .update (accept),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;
  assign idle      = (inflight == '0) && !accept;

  // turn the one-hot grant into an index and pick that requester's operands
  always_comb begin
    win_id = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_id = IDB'(i);
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // issue register: winner's operands, or zeros as a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      mul_a <= accept ? sel_a : '0;
      mul_b <= accept ? sel_b : '0;
    end
  end

  // tag shift register, free-running like the multiplier itself
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      for (int s = 0; s <= STAGES; s++) tag_id[s] <= '0;
    end else begin
      tag_v     <= {tag_v[STAGES-1:0], accept};
      tag_id[0] <= accept ? win_id : '0;
      for (int s = 1; s <= STAGES; s++) tag_id[s] <= tag_id[s-1];
    end
  end

  // return register: product is only passed through when a live tag matches it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
    end else begin
      rsp_valid   <= tag_v[STAGES];
      rsp_id      <= tag_id[STAGES];
      rsp_product <= tag_v[STAGES] ? mul_product : '0;
    end
  end

  // accepted-but-not-returned count; accept and return on one edge cancel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({accept, tag_v[STAGES]})
        2'b10:   inflight <= inflight + CNTB'(1);
        2'b01:   inflight <= inflight - CNTB'(1);
        default: inflight <= inflight;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_scheduler.sv
// tb/tb_mult_scheduler.sv - self-checking bench for mult_scheduler
module tb_mult_scheduler;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [7:0]  mul_a;
  logic [7:0]  mul_b;
  logic [15:0] mul_product;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_product;
  logic [2:0]  inflight;
  logic        idle;

  mult_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_product (mul_product),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .inflight    (inflight),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  // shared multiplier: three register stages, never reset
  logic [15:0] p0 = 16'd0, p1 = 16'd0, p2 = 16'd0;
  always @(posedge clk) begin
    p0 <= 16'(mul_a) * 16'(mul_b);
    p1 <= p0;
    p2 <= p1;
  end
  assign mul_product = p2;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int max_inflight = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  id;
    logic [15:0] prod;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   ptr_m = NREQ - 1;

  always @(posedge clk) cyc++;

  // scoreboard: predict grants with a reference round-robin, match responses in order
  always @(negedge clk) begin
    logic [3:0] pg;
    int         pid;
    int         idx;
    bit         found;
    exp_t       e;
    if (reset) begin
      sb.delete();
      ptr_m = NREQ - 1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_inflight", 32'(inflight), 32'd0);
    end else begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_id", 32'(rsp_id), 32'(e.id));
          check("sb_product", 32'(rsp_product), 32'(e.prod));
          check("sb_latency", 32'(cyc - e.cyc), 32'd5);
        end
      end
      check("sb_inflight", 32'(inflight), 32'(sb.size()));
      if (int'(inflight) > max_inflight) max_inflight = int'(inflight);
      pg = '0; pid = 0; found = 0;
      if (en) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (ptr_m + k) % NREQ;
          if (!found && req_valid[idx]) begin
            pg[idx] = 1'b1;
            pid     = idx;
            found   = 1;
          end
        end
      end
      check("sb_ready", 32'(req_ready), 32'(pg));
      check("sb_idle", 32'(idle), 32'((sb.size() == 0) && !found));
      if (found) begin
        e.id   = 2'(pid);
        e.prod = 16'(req_a[pid*8 +: 8]) * 16'(req_b[pid*8 +: 8]);
        e.cyc  = cyc;
        sb.push_back(e);
        ptr_m = pid;
      end
    end
  end

  task automatic wait_rsp(input string nm, input int id, input int prod, output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (!got && lat < 12) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) got = 1;
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got no rsp_valid, required rsp id=%0d product=%0d", nm, id, prod);
    end else begin
      check({nm, "_id"}, 32'(rsp_id), 32'(id));
      check({nm, "_product"}, 32'(rsp_product), 32'(prod));
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = '0;
    en        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    max_inflight = 0;
  endtask

  typedef struct {
    int id;
    int a;
    int b;
    int prod;
  } vec_t;

  vec_t vt[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;

    vt[0] = '{0, 15, 10, 150};
    vt[1] = '{3, 255, 255, 65025};
    vt[2] = '{2, 0, 9, 0};
    vt[3] = '{1, 12, 12, 144};
    vt[4] = '{0, 100, 25, 2500};
    vt[5] = '{2, 255, 1, 255};

    reset = 1'b1; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_b", 32'(mul_b), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_product", 32'(rsp_product), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;

    // single-requester vectors
    for (int v = 0; v < 6; v++) begin
      req_a[vt[v].id*8 +: 8] = 8'(vt[v].a);
      req_b[vt[v].id*8 +: 8] = 8'(vt[v].b);
      req_valid = 4'(1 << vt[v].id);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp($sformatf("vec%0d", v), vt[v].id, vt[v].prod, lat);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd5);
      @(posedge clk);
      #1;
    end

    // all four valid from reset: accepts 0,1,2,3 and back-to-back responses
    do_reset();
    req_a = {8'd0, 8'd3, 8'd255, 8'd100};
    req_b = {8'd9, 8'd7, 8'd255, 8'd25};
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1 req_valid[k] = 1'b0;
    end
    wait_rsp("all4_r0", 0, 2500, lat);
    wait_rsp("all4_r1", 1, 65025, lat);
    check("all4_b2b1", 32'(lat), 32'd1);
    wait_rsp("all4_r2", 2, 21, lat);
    check("all4_b2b2", 32'(lat), 32'd1);
    wait_rsp("all4_r3", 3, 0, lat);
    check("all4_b2b3", 32'(lat), 32'd1);
    check("all4_peak", 32'(max_inflight), 32'd4);

    // requesters 0 and 2 held valid: grants alternate
    do_reset();
    req_a = {8'd0, 8'd9, 8'd0, 8'd7};
    req_b = {8'd0, 8'd11, 8'd0, 8'd8};
    req_valid = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("alt%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd4);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    repeat (8) @(posedge clk);
    #1;

    // en low for three cycles while req1 waits
    do_reset();
    req_a[7:0] = 8'd5;  req_b[7:0] = 8'd6;
    req_valid = 4'b0001;
    @(posedge clk);
    #1;
    en = 1'b0;
    req_a[15:8] = 8'd12; req_b[15:8] = 8'd12;
    req_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("en_low_ready%0d", k), 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    en = 1'b1;
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp("en_r0", 0, 30, lat);
    wait_rsp("en_r1", 1, 144, lat);

    // reset two cycles after an accept discards the operation
    do_reset();
    req_a[7:0] = 8'd15; req_b[7:0] = 8'd10;
    req_valid = 4'b0001;
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("midrst_idle", 32'(idle), 32'd1);
      @(posedge clk);
    end
    #1 reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("postrst_inflight", 32'(inflight), 32'd0);
      check("postrst_idle", 32'(idle), 32'd1);
      @(posedge clk);
      #1;
    end
    req_a = {8'd4, 8'd0, 8'd0, 8'd2};
    req_b = {8'd5, 8'd0, 8'd0, 8'd3};
    req_valid = 4'b1001;
    @(negedge clk);
    check("postrst_first", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 4'b1000;
    @(negedge clk);
    check("postrst_second", 32'(req_ready), 32'd8);
    @(posedge clk);
    #1 req_valid = '0;
    wait_rsp("postrst_r0", 0, 6, lat);
    wait_rsp("postrst_r3", 3, 20, lat);

    // continuous stream from req1: accept and return on the same edge
    do_reset();
    req_valid = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      req_a[15:8] = 8'(k * 17 + 3);
      req_b[15:8] = 8'(k * 29 + 1);
      if (k >= 4) begin
        @(negedge clk);
        check($sformatf("stream_inflight%0d", k), 32'(inflight), 32'd4);
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("drain_inflight", 32'(inflight), 32'd0);
    check("drain_idle", 32'(idle), 32'd1);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
